// File: rtl/uart_rx_device_pkg.sv
// Shared definitions for the UART receiver device: receiver FSM states,
// register offsets, status bit positions and write-command bit positions.
package uart_rx_device_pkg;

    // Receiver line FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    // Register offsets within the 4-word device window
    localparam logic [1:0] OFF_STATUS = 2'd0;
    localparam logic [1:0] OFF_DATA   = 2'd1;

    // Status register bit positions
    localparam int STAT_AVAIL   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_FERR    = 3;
    localparam int STAT_CNT_LSB = 4;

    // Command bits written to the status offset
    localparam int CMD_POP      = 0;
    localparam int CMD_CLR_OVF  = 2;
    localparam int CMD_CLR_FERR = 3;

    // Receive FIFO geometry
    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_AW    = 2;
    localparam int FIFO_WIDTH = 8;

endpackage : uart_rx_device_pkg

// File: rtl/uart_rx_device_byte_fifo.sv
// Small register-based byte FIFO. A push into a full FIFO is accepted only
// when a pop happens in the same cycle; a pop of an empty FIFO is ignored,
// even if a push arrives in the same cycle.
module byte_fifo
    import uart_rx_device_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int WIDTH = FIFO_WIDTH
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [WIDTH-1:0]           o_head,
    output logic                       o_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == FULL_COUNT);
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_drop  = i_push && !w_do_push;

    // Storage: each entry captures the incoming byte when the write pointer lands on it
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (srst) begin
                    r_mem[gi] <= '0;
                end else if (w_do_push && (r_wr_ptr == AW'(gi))) begin
                    r_mem[gi] <= i_wdata;
                end
            end
        end
    endgenerate

    // Pointers wrap naturally modulo the depth; count tracks occupancy 0..DEPTH
    always_ff @(posedge clk) begin
        if (srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : byte_fifo

// File: rtl/uart_rx_device.sv
// UART 8N1 receiver with a 4-entry receive FIFO and a small memory-mapped
// register window (status at offset 0, data at offset 1).
module uart_rx_device
    import uart_rx_device_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [15:0] BASE_ADDR    = 16'h0010
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx,
    input  logic        write_enable,
    input  logic [15:0] address,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        rx_avail
);

    localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_LOAD  = 16'(CLKS_PER_BIT - 1);

    // Line synchronizer and edge history
    logic r_rx_meta;
    logic r_rx_sync;
    logic r_rx_prev;

    // Receiver state
    rx_state_t   r_state;
    rx_state_t   w_state_next;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_next;
    logic [2:0]  r_bit_idx;
    logic [2:0]  w_bit_idx_next;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_next;
    logic        w_push;
    logic        w_frame_bad;

    // Sticky flags and bus read register
    logic        r_overflow;
    logic        r_frame_err;
    logic [15:0] r_data_out;
    logic [15:0] w_rd_data;
    logic [15:0] w_status;

    // FIFO interface
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [FIFO_AW:0]   w_fifo_count;
    logic [7:0]         w_fifo_head;
    logic               w_fifo_drop;

    // Bus decode
    logic       w_sel;
    logic [1:0] w_offset;
    logic       w_wr_cmd;
    logic       w_pop;
    logic       w_unused_bits;

    assign w_sel    = (address[15:2] == BASE_ADDR[15:2]);
    assign w_offset = address[1:0];
    assign w_wr_cmd = write_enable && w_sel && (w_offset == OFF_STATUS);
    assign w_pop    = w_wr_cmd && data_in[CMD_POP];
    assign w_unused_bits = ^{data_in[15:4], data_in[1]};

    // Two-flop synchronizer plus one history flop for falling-edge detection
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // Receiver FSM state register and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
        end
    end

    // Receiver FSM next-state: half-bit wait to mid-start, then full-bit steps to mid-bit samples
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_push         = 1'b0;
        w_frame_bad    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_rx_prev && !r_rx_sync) begin
                    w_state_next = ST_START;
                    w_cnt_next   = HALF_LOAD;
                end
            end
            ST_START: begin
                if (r_cnt == '0) begin
                    if (!r_rx_sync) begin
                        w_state_next   = ST_DATA;
                        w_cnt_next     = BIT_LOAD;
                        w_bit_idx_next = '0;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt - 16'd1;
                end
            end
            ST_DATA: begin
                if (r_cnt == '0) begin
                    w_shift_next = {r_rx_sync, r_shift[7:1]};
                    w_cnt_next   = BIT_LOAD;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = ST_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt - 16'd1;
                end
            end
            ST_STOP: begin
                if (r_cnt == '0) begin
                    w_push       = r_rx_sync;
                    w_frame_bad  = !r_rx_sync;
                    w_state_next = ST_IDLE;
                end else begin
                    w_cnt_next = r_cnt - 16'd1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_WIDTH)
    ) u_fifo (
        .clk     (clock),
        .srst    (reset),
        .i_push  (w_push),
        .i_wdata (r_shift),
        .i_pop   (w_pop),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count),
        .o_head  (w_fifo_head),
        .o_drop  (w_fifo_drop)
    );

    // Sticky error flags: a set in the same cycle as a clear takes priority
    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_fifo_drop) begin
                r_overflow <= 1'b1;
            end else if (w_wr_cmd && data_in[CMD_CLR_OVF]) begin
                r_overflow <= 1'b0;
            end
            if (w_frame_bad) begin
                r_frame_err <= 1'b1;
            end else if (w_wr_cmd && data_in[CMD_CLR_FERR]) begin
                r_frame_err <= 1'b0;
            end
        end
    end

    // Read mux: status word, head byte, or zero for anything else
    always_comb begin
        w_status = '0;
        w_status[STAT_AVAIL]          = !w_fifo_empty;
        w_status[STAT_FULL]           = w_fifo_full;
        w_status[STAT_OVF]            = r_overflow;
        w_status[STAT_FERR]           = r_frame_err;
        w_status[STAT_CNT_LSB +: 3]   = w_fifo_count;
        w_rd_data = '0;
        if (w_sel) begin
            case (w_offset)
                OFF_STATUS: w_rd_data = w_status;
                OFF_DATA:   w_rd_data = w_fifo_empty ? 16'h0000 : {8'h00, w_fifo_head};
                default:    w_rd_data = '0;
            endcase
        end
    end

    // Registered read data gives a one-cycle, memory-like read latency
    always_ff @(posedge clock) begin
        if (reset) begin
            r_data_out <= '0;
        end else begin
            r_data_out <= w_rd_data;
        end
    end

    assign data_out = r_data_out;
    assign rx_avail = !w_fifo_empty;

endmodule : uart_rx_device

// File: tb/tb_uart_rx_device.sv
// Self-checking bench for uart_rx_device: directed frames plus a randomized
// phase, all compared against a queue-based model of the receive path.
module tb_uart_rx_device;

    localparam int          C    = 8;
    localparam logic [15:0] BASE = 16'h0010;

    logic        clk;
    logic        reset;
    logic        rx;
    logic        write_enable;
    logic [15:0] address;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        rx_avail;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state
    bit [7:0] q[$];
    bit       m_ovf;
    bit       m_ferr;

    uart_rx_device #(
        .CLKS_PER_BIT (C),
        .BASE_ADDR    (BASE)
    ) dut (
        .clock        (clk),
        .reset        (reset),
        .rx           (rx),
        .write_enable (write_enable),
        .address      (address),
        .data_in      (data_in),
        .data_out     (data_out),
        .rx_avail     (rx_avail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [15:0] model_status();
        logic [15:0] s;
        s = 16'h0000;
        s[0]   = (q.size() != 0);
        s[1]   = (q.size() == 4);
        s[2]   = m_ovf;
        s[3]   = m_ferr;
        s[6:4] = 3'(q.size());
        return s;
    endfunction

    function automatic logic [15:0] model_data();
        return (q.size() != 0) ? {8'h00, q[0]} : 16'h0000;
    endfunction

    // Model of a received frame
    task automatic model_rx(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok)          m_ferr = 1'b1;
        else if (q.size() == 4) m_ovf = 1'b1;
        else                    q.push_back(b);
    endtask

    // Model of a command write to the status offset
    task automatic model_cmd(input logic [15:0] d);
        if (d[0] && q.size() != 0) void'(q.pop_front());
        if (d[2]) m_ovf  = 1'b0;
        if (d[3]) m_ferr = 1'b0;
    endtask

    // All tasks are entered 1 time unit after a rising edge
    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        address = a;
        @(posedge clk); #1;
        d = data_out;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        address      = a;
        data_in      = d;
        write_enable = 1'b1;
        @(posedge clk); #1;
        write_enable = 1'b0;
        data_in      = 16'h0000;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_bit);
        rx = 1'b0;
        repeat (C) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (C) @(posedge clk);
            #1;
        end
        rx = stop_bit;
        repeat (C) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag);
        logic [15:0] d;
        bus_read(BASE, d);
        check({tag, "_stat"}, d, model_status());
        bus_read(BASE + 16'd1, d);
        check({tag, "_data"}, d, model_data());
        check({tag, "_avail"}, {15'd0, rx_avail}, {15'd0, q.size() != 0});
    endtask

    initial begin
        logic [15:0] d;
        logic [7:0]  b;
        int          op;

        reset = 1'b1; rx = 1'b1; write_enable = 1'b0;
        address = BASE; data_in = 16'h0000;
        m_ovf = 1'b0; m_ferr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", data_out, 16'h0000);
        check("rst_avail", {15'd0, rx_avail}, 16'h0000);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_regs("reset");

        // Single frame and read-window decode
        send_frame(8'hA5, 1'b1); model_rx(8'hA5, 1'b1);
        bus_read(16'h0010, d); check("a5_stat", d, 16'h0011);
        bus_read(16'h0011, d); check("a5_data", d, 16'h00A5);
        bus_read(16'h0012, d); check("off2", d, 16'h0000);
        bus_read(16'h0013, d); check("off3", d, 16'h0000);
        bus_read(16'h0014, d); check("unsel", d, 16'h0000);
        bus_read(16'h0011, d); check("no_side_eff", d, 16'h00A5);
        bus_write(BASE, 16'h0001); model_cmd(16'h0001);
        check_regs("a5_pop");

        // Five frames, no pops: fill, overflow, drain
        for (int i = 1; i <= 5; i++) begin
            b = 8'(i);
            send_frame(b, 1'b1); model_rx(b, 1'b1);
        end
        bus_read(BASE, d);             check("five_stat", d, 16'h0047);
        bus_read(BASE + 16'd1, d);     check("five_data", d, 16'h0001);
        for (int i = 1; i <= 4; i++) begin
            bus_read(BASE + 16'd1, d); check("drain", d, 16'(i));
            bus_write(BASE, 16'h0001); model_cmd(16'h0001);
        end
        bus_read(BASE, d);             check("drained_stat", d, 16'h0004);
        bus_write(BASE, 16'h0004); model_cmd(16'h0004);
        check_regs("ovf_clr");

        // Bad stop bit
        send_frame(8'h3C, 1'b0); model_rx(8'h3C, 1'b0);
        bus_read(BASE, d);             check("ferr_stat", d, 16'h0008);
        bus_write(BASE, 16'h0008); model_cmd(16'h0008);
        bus_read(BASE, d);             check("ferr_clr", d, 16'h0000);

        // Two-clock glitch on the line
        rx = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        bus_read(BASE, d);             check("glitch_stat", d, 16'h0000);

        // Reset in the middle of data bit 3, held until the line is idle
        send_frame(8'h11, 1'b1); model_rx(8'h11, 1'b1);
        fork
            send_frame(8'hC3, 1'b1);
            begin
                repeat (36) @(posedge clk);
                #1;
                reset = 1'b1;
            end
        join
        @(posedge clk); #1;
        reset = 1'b0;
        q.delete(); m_ovf = 1'b0; m_ferr = 1'b0;
        bus_read(BASE, d);             check("midrst_stat", d, 16'h0000);
        send_frame(8'h5A, 1'b1); model_rx(8'h5A, 1'b1);
        bus_read(BASE + 16'd1, d);     check("after_rst", d, 16'h005A);
        bus_write(BASE, 16'h0001); model_cmd(16'h0001);

        // Full FIFO with a pop landing on the stop-bit sample edge
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1); model_rx(b, 1'b1);
        end
        b = 8'($urandom);
        fork
            send_frame(b, 1'b1);
            begin
                repeat (78) @(posedge clk);
                #1;
                bus_write(BASE, 16'h0001);
            end
        join
        void'(q.pop_front());
        q.push_back(b);
        bus_read(BASE, d);             check("coinc_stat", d, 16'h0043);
        for (int i = 0; i < 4; i++) begin
            bus_read(BASE + 16'd1, d); check("coinc_drain", d, model_data());
            bus_write(BASE, 16'h0001); model_cmd(16'h0001);
        end
        check_regs("coinc_empty");

        // Randomized phase
        for (int it = 0; it < 16; it++) begin
            op = int'($urandom_range(0, 3));
            if (op <= 1) begin
                bit ok;
                b  = 8'($urandom);
                ok = ($urandom_range(0, 7) != 0);
                send_frame(b, ok); model_rx(b, ok);
            end else if (op == 2) begin
                d = 16'($urandom);
                bus_write(BASE, d); model_cmd(d);
            end else begin
                bus_write(BASE + 16'(int'($urandom_range(1, 3))), 16'hFFFF);
                bus_read(16'h0100 + 16'($urandom_range(0, 255)), d);
                check("rnd_unsel", d, 16'h0000);
            end
            check_regs("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_uart_rx_device

// File: doc/uart_rx_device.md
UART_RX_DEVICE -- requirements
Module: uart_rx_device

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clocks per serial bit, legal range 4..65535.
REQ-002 SHALL have parameter BASE_ADDR, default 16'h0010, device base address; bits [1:0] ignored.
REQ-003 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, 8N1 framing, idle high.
REQ-006 SHALL have port write_enable  input  1  device-bus write strobe.
REQ-007 SHALL have port address  input  16  device-bus address, for reads and writes.
REQ-008 SHALL have port data_in  input  16  device-bus write data.
REQ-009 SHALL have port data_out  output  16  registered device-bus read data.
REQ-010 SHALL have port rx_avail  output  1  high while the FIFO is non-empty.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer with reset value 1; all line logic uses the synchronized value.
REQ-012 SHALL implement FSM IDLE, START, DATA, STOP.
REQ-013 IDLE: on a synchronized falling edge, load counter with CLKS_PER_BIT/2-1 and go to START.
REQ-014 START: at counter zero, sample the line; low goes to DATA with bit index 0, high (glitch) goes to IDLE with no other effect.
REQ-015 DATA: wait CLKS_PER_BIT clocks per bit, sample at mid-bit, shift LSB first; after bit 7 go to STOP.
REQ-016 STOP: after CLKS_PER_BIT clocks, sample; high pushes the byte, low sets frame_err and discards the byte; both go to IDLE.
REQ-017 SHALL make a pushed byte visible in status/data on the clock after the stop-bit sample.
REQ-018 SHALL buffer bytes in a 4-entry FIFO; count occupies 0..4 with pointer wrap modulo 4.
REQ-019 Push when full without a same-cycle pop: drop the byte, set sticky overflow.
REQ-020 Push and pop in the same cycle: when full, both occur with count unchanged and no overflow; when empty, the push occurs and the pop is ignored.
REQ-021 Pop when empty: no effect.
REQ-022 SHALL select the device when address[15:2] == BASE_ADDR[15:2]; offset = address[1:0].
REQ-023 Offset 0 read (status): bit0 rx_avail, bit1 full, bit2 overflow, bit3 frame_err, bits[6:4] count, other bits 0.
REQ-024 Offset 1 read (data): head byte zero-extended to 16 bits; 16'h0000 when empty.
REQ-025 Offsets 2-3 and unselected addresses SHALL read 16'h0000.
REQ-026 SHALL register data_out: the value for the address sampled at edge N appears after edge N, giving one-cycle read latency like memory.
REQ-027 Reads SHALL have no side effects.
REQ-028 Selected write to offset 0: data_in bit0 pops the head, bit2 clears overflow, bit3 clears frame_err; the bits act independently.
REQ-029 Writes to other offsets SHALL be ignored.
REQ-030 When a sticky flag is set and cleared in the same cycle, set SHALL win.

Reset
REQ-031 On reset: FSM to IDLE, counters and bit index 0, FIFO empty, overflow and frame_err 0, synchronizer 1, data_out 16'h0000, rx_avail 0.
REQ-032 Reset mid-frame SHALL abandon the partial byte; reception resumes from the next falling edge after reset deasserts.

Structure
REQ-033 Shared package SHALL hold FSM state encodings, register offsets (STATUS=0, DATA=1), status bit positions, and write-command bit positions.
REQ-034 The FIFO SHALL be a separate sub-module byte_fifo (depth 4, width 8, push/pop/full/empty/count, synchronous reset).

Verification (bench CLKS_PER_BIT=8, BASE_ADDR=16'h0010)
REQ-035 Frame 0xA5 -> read 0x0010 returns 16'h0011; read 0x0011 returns 16'h00A5.
REQ-036 Frames 0x01..0x05 with no pops -> status 16'h0047, data 16'h0001; four pops return 01,02,03,04, then status 16'h0004.
REQ-037 Frame 0x3C with stop bit low -> status 16'h0008, count 0; write 16'h0008 to 0x0010 -> status 16'h0000.
REQ-038 rx low for 2 clocks only -> FSM returns to IDLE, no push, status 16'h0000.
REQ-039 Reset asserted during DATA bit 3 -> status 16'h0000; the following frame 0x5A is received as 16'h005A.
REQ-040 FIFO full plus pop write coincident with a stop sample -> count stays 4, overflow 0, new byte at tail.
